alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the ALU interface. Accepts operation requests over valid/ready and drives the
//  registered ALU's alu_ctrl and operand ports. It captures the result and the {V,Z,C,N} checks one
//  cycle after issue, keeps the architectural NZCV flag register and evaluates an ARM condition code.
//  Multi-bit shifts, rotates and inc/dec are built by repeating the ALU's 1-step ops and feeding
//  each result back in. Sits between decode/control and the ALU in the single-cycle core.
// PARAMETERS
//  DATA_W   32  operand/result width
//  OP_W     6   ALU op-code width
//  CNT_W    5   repeat-count width
//  IDLE_OP  63  op code driven when no op is in flight (ALU default: result 0, checks 4'b0100)
// PORTS
//  alu_clk        in   1       single clock; all state updates on posedge
//  alu_rst        in   1       synchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       1 only in IDLE and alu_rst low
//  req_op         in   OP_W    ALU op code (0-23 defined)
//  req_a          in   DATA_W  operand A
//  req_b          in   DATA_W  operand B
//  req_cnt        in   CNT_W   repeat count; ops 4-7, 16-23 only
//  req_setf       in   1       1: final checks written to flags_q
//  req_cond       in   4       ARM condition code to evaluate
//  alu_ctrl       out  OP_W    to ALU op select
//  alu_op_a       out  DATA_W  to ALU in_1
//  alu_op_b       out  DATA_W  to ALU in_2
//  alu_rslt       in   DATA_W  from ALU, valid 1 cycle after issue
//  alu_checks     in   4       from ALU, {V,Z,C,N} = bits [3:0]
//  rsp_valid      out  1       response present
//  rsp_ready      in   1       response accepted
//  rsp_rslt       out  DATA_W  final result
//  rsp_flags      out  4       flags used for the condition, {V,Z,C,N}
//  rsp_cond_true  out  1       req_cond satisfied by rsp_flags
//  flags_q        out  4       architectural flag register {V,Z,C,N}
// BEHAVIOUR
//  Reset values (alu_rst=1 at posedge)
//   - State IDLE; alu_ctrl=IDLE_OP; alu_op_a/b=0; rsp_* =0; flags_q=0.
//   - Reset mid-operation aborts the op: no response, no flag write.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | RESP) -> IDLE
//   - IDLE: req_valid&&req_ready latches op, operands, cond and setf, and registers alu_ctrl/alu_op_a/alu_op_b.
//     passes = (op in 4-7 or 16-23) ? max(req_cnt,1) : 1. Go to ISSUE.
//   - ISSUE: ALU inputs held stable; the ALU samples them at this cycle's end edge. Go to WAIT.
//   - WAIT: at the end edge, capture alu_rslt/alu_checks.
//     - If passes_left>1: decrement and feed the result back into operand A (even op) or operand B (odd op), then go to ISSUE.
//     - Else go to RESP.
//   - RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&&rsp_ready: go to IDLE and drive alu_ctrl=IDLE_OP.
//  Latency and throughput
//   - rsp_valid rises 2*passes cycles after the accept edge.
//   - No overlap: a new request is accepted no earlier than 1 cycle after the response handshake.
//  Flags
//   - Intermediate-pass checks are discarded.
//   - setf=1: flags_q <= final checks at the final WAIT edge, and rsp_flags = final checks.
//   - setf=0: flags_q unchanged, and rsp_flags = flags_q.
//  Conditions: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z;
//   GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL(1110) 1; 1111 never (0).
//  Undefined op (24-63): issued once and the ALU result is passed through unchanged (0, checks 4'b0100).
//  Widths: no arithmetic on data in this block; the repeat counter is CNT_W bits and never wraps below 1.
// STRUCTURE
//  Shared package alu_pkg: ALU op-code localparams (0-23), IDLE_OP, flag bit indices (V=3,Z=2,C=1,N=0),
//   condition-code localparams, FSM state encoding.
//  One sub-module: alu_cond_eval (combinational: cond[3:0], flags[3:0] -> true).
// TESTING
//  1 ADD(0) a=5 b=7 setf=1 cond=EQ -> rslt=12, flags=4'b0000, cond_true=0, rsp_valid 2 cycles after accept.
//  2 SUB(1) a=3 b=3 setf=1 cond=EQ -> rslt=0, flags_q=4'b0100, cond_true=1; then ADD 1+1 setf=0 cond=NE -> flags_q stays 4'b0100, cond_true=0.
//  3 SHL-A(16) a=1 cnt=4 -> 4 ALU issues seen, rslt=32'h10, rsp_valid 8 cycles after accept; cnt=0 -> 1 pass, rslt=2.
//  4 ROL-B(21) b=32'h8000_0001 cnt=1 -> rslt=32'h0000_0003; odd-op feedback on B checked with cnt=2 -> 32'h0000_0006.
//  5 rsp_ready low 3 cycles -> rsp_valid/rsp_rslt/rsp_flags stable, req_ready=0, alu_ctrl unchanged; handshake -> IDLE, alu_ctrl=63.
//  6 alu_rst high during WAIT of a cnt=4 op -> next cycle IDLE, rsp_valid=0, flags_q=0, alu_ctrl=63, no late response.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer and its condition evaluator:
//   - default widths and the idle op code
//   - ALU op codes 0-23 (ops that take a repeat count: 4-7 and 16-23)
//   - bit positions inside the {V,Z,C,N} check/flag vector
//   - ARM condition codes
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;
  localparam int CNT_W_DEF  = 5;

  // Op code the ALU sees when nothing is in flight; the ALU answers it with
  // result 0 and checks 4'b0100.
  localparam int unsigned ALU_IDLE_OP = 63;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_INC_A = 4;
  localparam int unsigned OP_INC_B = 5;
  localparam int unsigned OP_DEC_A = 6;
  localparam int unsigned OP_DEC_B = 7;
  localparam int unsigned OP_XOR   = 8;
  localparam int unsigned OP_NOT_A = 9;
  localparam int unsigned OP_NOT_B = 10;
  localparam int unsigned OP_PASS_A = 11;
  localparam int unsigned OP_PASS_B = 12;
  localparam int unsigned OP_NEG_A = 13;
  localparam int unsigned OP_NEG_B = 14;
  localparam int unsigned OP_CMP   = 15;
  localparam int unsigned OP_SHL_A = 16;
  localparam int unsigned OP_SHL_B = 17;
  localparam int unsigned OP_SHR_A = 18;
  localparam int unsigned OP_SHR_B = 19;
  localparam int unsigned OP_ROL_A = 20;
  localparam int unsigned OP_ROL_B = 21;
  localparam int unsigned OP_ROR_A = 22;
  localparam int unsigned OP_ROR_B = 23;

  localparam int FLAG_V = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Inc/dec and the shift/rotate family are 1-step ALU ops that the
  // sequencer repeats to build multi-step versions.
  function automatic logic is_repeat_op(input int unsigned op);
    return ((op >= OP_INC_A) && (op <= OP_DEC_B)) ||
           ((op >= OP_SHL_A) && (op <= OP_ROR_B));
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// ---------------------------------------------------------------------------
// alu_cond_eval
// Combinational ARM condition-code evaluation against a {V,Z,C,N} vector.
// Ports:
//   cond  in  4  condition code (EQ..AL, 4'b1111 = never)
//   flags in  4  {V,Z,C,N}
//   true  out 1  condition satisfied
// ---------------------------------------------------------------------------
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       true
);

  logic w_v, w_z, w_c, w_n;

  assign w_v = flags[FLAG_V];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_n = flags[FLAG_N];

  always_comb begin
    true = 1'b0;
    case (cond)
      COND_EQ: true = w_z;
      COND_NE: true = ~w_z;
      COND_CS: true = w_c;
      COND_CC: true = ~w_c;
      COND_MI: true = w_n;
      COND_PL: true = ~w_n;
      COND_VS: true = w_v;
      COND_VC: true = ~w_v;
      COND_HI: true = w_c & ~w_z;
      COND_LS: true = ~w_c | w_z;
      COND_GE: true = (w_n == w_v);
      COND_LT: true = (w_n != w_v);
      COND_GT: true = ~w_z & (w_n == w_v);
      COND_LE: true = w_z | (w_n != w_v);
      COND_AL: true = 1'b1;
      default: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Initiator side of the registered-ALU interface. Takes one operation
// request at a time, drives the ALU op select and operands, captures the
// result and checks one cycle after each issue, repeats 1-step ops with the
// result fed back, keeps the architectural NZCV register and evaluates the
// requested condition against the response flags.
//
// Ports:
//   alu_clk, alu_rst                 clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_op/a/b/cnt/setf/cond         request payload
//   alu_ctrl, alu_op_a, alu_op_b     to the ALU (registered)
//   alu_rslt, alu_checks             from the ALU, 1 cycle after issue
//   rsp_valid/rsp_ready              response handshake
//   rsp_rslt, rsp_flags, rsp_cond_true  response payload, held until taken
//   flags_q                          architectural flags {V,Z,C,N}
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ALU parked on the idle op, req_ready high
// ST_ISSUE | operands stable; ALU samples them at the end of this cycle
// ST_WAIT  | ALU output valid; captured at the end of this cycle
// ST_RESP  | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          OP_W    = OP_W_DEF,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned IDLE_OP = ALU_IDLE_OP
) (
  input  logic              alu_clk,
  input  logic              alu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CNT_W-1:0]  req_cnt,
  input  logic              req_setf,
  input  logic [3:0]        req_cond,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic [3:0]        alu_checks,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rslt,
  output logic [3:0]        rsp_flags,
  output logic              rsp_cond_true,
  output logic [3:0]        flags_q
);

  localparam logic [OP_W-1:0]  IDLE_CTRL = OP_W'(IDLE_OP);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_e        r_state, w_state_nxt;
  logic [OP_W-1:0]   r_ctrl, w_ctrl_nxt;
  logic [DATA_W-1:0] r_op_a, w_op_a_nxt;
  logic [DATA_W-1:0] r_op_b, w_op_b_nxt;
  logic [CNT_W-1:0]  r_passes, w_passes_nxt;
  logic              r_setf, w_setf_nxt;
  logic [3:0]        r_cond, w_cond_nxt;
  logic [3:0]        r_flags, w_flags_nxt;
  logic [DATA_W-1:0] r_rsp_rslt, w_rsp_rslt_nxt;
  logic [3:0]        r_rsp_flags, w_rsp_flags_nxt;
  logic              r_rsp_true, w_rsp_true_nxt;

  logic              w_accept;
  logic [CNT_W-1:0]  w_passes_init;
  logic [3:0]        w_final_flags;
  logic              w_final_true;

  assign req_ready = (r_state == ST_IDLE) && !alu_rst;
  assign w_accept  = req_valid && req_ready;

  // A repeat count of 0 still runs the op once.
  assign w_passes_init = is_repeat_op(32'(req_op))
                       ? ((req_cnt == '0) ? CNT_ONE : req_cnt)
                       : CNT_ONE;

  // Flags reported with the response: fresh checks when the op writes the
  // flag register, otherwise the register as it stands.
  assign w_final_flags = r_setf ? alu_checks : r_flags;

  alu_cond_eval u_cond_eval (
    .cond  (r_cond),
    .flags (w_final_flags),
    .true  (w_final_true)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_ctrl_nxt      = r_ctrl;
    w_op_a_nxt      = r_op_a;
    w_op_b_nxt      = r_op_b;
    w_passes_nxt    = r_passes;
    w_setf_nxt      = r_setf;
    w_cond_nxt      = r_cond;
    w_flags_nxt     = r_flags;
    w_rsp_rslt_nxt  = r_rsp_rslt;
    w_rsp_flags_nxt = r_rsp_flags;
    w_rsp_true_nxt  = r_rsp_true;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_ctrl_nxt   = req_op;
          w_op_a_nxt   = req_a;
          w_op_b_nxt   = req_b;
          w_setf_nxt   = req_setf;
          w_cond_nxt   = req_cond;
          w_passes_nxt = w_passes_init;
          w_state_nxt  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        if (r_passes > CNT_ONE) begin
          w_passes_nxt = r_passes - CNT_ONE;
          // Even op codes are the "_A" variants and odd the "_B" variants,
          // so bit 0 picks which operand carries the running value.
          if (r_ctrl[0]) begin
            w_op_b_nxt = alu_rslt;
          end else begin
            w_op_a_nxt = alu_rslt;
          end
          w_state_nxt = ST_ISSUE;
        end else begin
          w_rsp_rslt_nxt  = alu_rslt;
          w_rsp_flags_nxt = w_final_flags;
          w_rsp_true_nxt  = w_final_true;
          if (r_setf) begin
            w_flags_nxt = alu_checks;
          end
          w_state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_ctrl_nxt  = IDLE_CTRL;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_ctrl_nxt  = IDLE_CTRL;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= IDLE_CTRL;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_passes    <= CNT_ONE;
      r_setf      <= 1'b0;
      r_cond      <= '0;
      r_flags     <= '0;
      r_rsp_rslt  <= '0;
      r_rsp_flags <= '0;
      r_rsp_true  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_op_a      <= w_op_a_nxt;
      r_op_b      <= w_op_b_nxt;
      r_passes    <= w_passes_nxt;
      r_setf      <= w_setf_nxt;
      r_cond      <= w_cond_nxt;
      r_flags     <= w_flags_nxt;
      r_rsp_rslt  <= w_rsp_rslt_nxt;
      r_rsp_flags <= w_rsp_flags_nxt;
      r_rsp_true  <= w_rsp_true_nxt;
    end
  end

  assign alu_ctrl      = r_ctrl;
  assign alu_op_a      = r_op_a;
  assign alu_op_b      = r_op_b;
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_rslt      = r_rsp_rslt;
  assign rsp_flags     = r_rsp_flags;
  assign rsp_cond_true = r_rsp_true;
  assign flags_q       = r_flags;

endmodule
